// File: rtl/pc_seq_pkg.sv
// Shared constants for the fetch-stage sequencer: npc opcodes, FSM encoding
// and the default reset PC.
package pc_seq_pkg;

  localparam logic [1:0] NPCOP_PLUS4  = 2'b00;
  localparam logic [1:0] NPCOP_BRANCH = 2'b01;
  localparam logic [1:0] NPCOP_ABS    = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/pc_seq_npc.sv
// Next-PC datapath: sequential pc+4, PC-relative branch target, or absolute
// address, selected by npcop.
module signext (
  input  logic [15:0] imm,
  output logic [31:0] ext
);
  assign ext = {{16{imm[15]}}, imm};
endmodule

module npc
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pcplus,
  input  logic [15:0] offset,
  input  logic [31:0] absaddress,
  input  logic [1:0]  npcop,
  output logic [31:0] next_pc,
  output logic [31:0] pc4
);
  logic [31:0] offset_ext;
  logic [31:0] br_tgt;

  signext u_signext (
    .imm (offset),
    .ext (offset_ext)
  );

  assign pc4    = pc + 32'd4;
  assign br_tgt = pcplus + {offset_ext[29:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    case (npcop)
      NPCOP_BRANCH: next_pc = br_tgt;
      NPCOP_ABS:    next_pc = absaddress;
      default:      next_pc = pc4;
    endcase
  end
endmodule

// File: rtl/pc_seq.sv
// Fetch-stage sequencer: owns the PC, runs the imem req/ack handshake and
// applies D-stage redirects with delay-slot semantics.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        dec_valid_i,
  input  logic        br_i,
  input  logic        br_taken_i,
  input  logic        j_i,
  input  logic        jr_i,
  input  logic [31:0] pcplusD_i,
  input  logic [15:0] offset_i,
  input  logic [25:0] jidx_i,
  input  logic [31:0] rs_i,
  input  logic        imem_ack_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus_o,
  output logic        if_valid_o
);
  logic [1:0]  state;
  logic [31:0] pc;
  logic        pend_v;
  logic [31:0] pend_tgt;
  logic        redir;
  logic        accept;
  logic [1:0]  npcop;
  logic [31:0] absaddress;
  logic [31:0] next_pc;
  logic [31:0] pc4;
  logic [31:0] j_tgt;

  assign redir  = dec_valid_i & ~stall_i & (jr_i | j_i | (br_i & br_taken_i));
  assign j_tgt  = {pcplusD_i[31:28], jidx_i, 2'b00};
  // An ack seen while reset is asserted must not be accepted into IF/ID.
  assign accept = rst & (state == S_FETCH) & imem_ack_i & ~stall_i;

  always_comb begin
    npcop      = NPCOP_PLUS4;
    absaddress = '0;
    if (pend_v) begin
      npcop      = NPCOP_ABS;
      absaddress = pend_tgt;
    end else if (redir && jr_i) begin
      npcop      = NPCOP_ABS;
      absaddress = rs_i;
    end else if (redir && j_i) begin
      npcop      = NPCOP_ABS;
      absaddress = j_tgt;
    end else if (redir) begin
      npcop = NPCOP_BRANCH;
    end
  end

  npc u_npc (
    .pc         (pc),
    .pcplus     (pcplusD_i),
    .offset     (offset_i),
    .absaddress (absaddress),
    .npcop      (npcop),
    .next_pc    (next_pc),
    .pc4        (pc4)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      pend_v   <= 1'b0;
      pend_tgt <= '0;
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack_i) begin
            if (stall_i) state <= S_HOLD;
            else         pc    <= next_pc;
          end
        end
        S_HOLD:  if (!stall_i) state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
      // With no accepting ack this cycle, next_pc already holds the resolved
      // redirect target, so it is parked until the delay-slot fetch completes.
      if (accept) begin
        pend_v <= 1'b0;
      end else if (redir && !pend_v) begin
        pend_v   <= 1'b1;
        pend_tgt <= next_pc;
      end
    end
  end

  assign imem_req_o  = (state == S_FETCH);
  assign imem_addr_o = pc;
  assign pc_o        = pc;
  assign pcplus_o    = pc4;
  assign if_valid_o  = accept;
endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: handshake, wait states, redirects, stall,
// reset mid-fetch and address wrap.
module tb_pc_seq;
  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        dec_valid_i;
  logic        br_i;
  logic        br_taken_i;
  logic        j_i;
  logic        jr_i;
  logic [31:0] pcplusD_i;
  logic [15:0] offset_i;
  logic [25:0] jidx_i;
  logic [31:0] rs_i;
  logic        imem_ack_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] pcplus_o;
  logic        if_valid_o;

  int unsigned n_cmp;
  int unsigned n_bad;

  pc_seq #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .dec_valid_i (dec_valid_i),
    .br_i        (br_i),
    .br_taken_i  (br_taken_i),
    .j_i         (j_i),
    .jr_i        (jr_i),
    .pcplusD_i   (pcplusD_i),
    .offset_i    (offset_i),
    .jidx_i      (jidx_i),
    .rs_i        (rs_i),
    .imem_ack_i  (imem_ack_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .pc_o        (pc_o),
    .pcplus_o    (pcplus_o),
    .if_valid_o  (if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    dec_valid_i = 1'b0;
    br_i = 1'b0; br_taken_i = 1'b0; j_i = 1'b0; jr_i = 1'b0;
    pcplusD_i = '0; offset_i = '0; jidx_i = '0; rs_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0;
    clear_dec();
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b1;
    clear_dec();
    tick(); tick();
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    n_cmp++;
    if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", if_valid_o); end
    n_cmp++;
    if (pc_o !== 32'h0000_3000) begin n_bad++; $display("FAIL reset_pc got %h want 00003000", pc_o); end
    n_cmp++;
    if (pcplus_o !== 32'h0000_3004) begin n_bad++; $display("FAIL reset_pcplus got %h want 00003004", pcplus_o); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack req=%b valid=%b want 0 0", imem_req_o, if_valid_o);
    end
    tick();
    n_cmp++;
    if (imem_req_o !== 1'b1 || pc_o !== 32'h0000_3000) begin
      n_bad++; $display("FAIL first_req req=%b pc=%h want 1 00003000", imem_req_o, pc_o);
    end
  endtask

  task automatic test_seq();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h0000_3000; exp_addr[1] = 32'h0000_3004; exp_addr[2] = 32'h0000_3008;
    imem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (imem_addr_o !== exp_addr[i] || if_valid_o !== 1'b1 || imem_req_o !== 1'b1) begin
        n_bad++;
        $display("FAIL seq_%0d addr=%h valid=%b req=%b want %h 1 1", i, imem_addr_o, if_valid_o, imem_req_o, exp_addr[i]);
      end
      tick();
    end
  endtask

  task automatic test_wait();
    do_reset();
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (imem_addr_o !== 32'h0000_3004 || if_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
        n_bad++;
        $display("FAIL wait_%0d addr=%h valid=%b req=%b want 00003004 0 1", i, imem_addr_o, if_valid_o, imem_req_o);
      end
      tick();
    end
    imem_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (imem_addr_o !== 32'h0000_3004 || if_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL wait_ack addr=%h valid=%b want 00003004 1", imem_addr_o, if_valid_o);
    end
    tick();
    n_cmp++;
    if (imem_addr_o !== 32'h0000_3008 || pcplus_o !== 32'h0000_300C) begin
      n_bad++; $display("FAIL wait_next addr=%h pcplus=%h want 00003008 0000300c", imem_addr_o, pcplus_o);
    end
  endtask

  task automatic test_branch();
    imem_ack_i = 1'b1;
    dec_valid_i = 1'b1; br_i = 1'b1; br_taken_i = 1'b1;
    pcplusD_i = 32'h0000_300C; offset_i = 16'hFFFC;
    #1;
    n_cmp++;
    if (if_valid_o !== 1'b1) begin n_bad++; $display("FAIL br_valid got %b want 1", if_valid_o); end
    tick();
    clear_dec();
    n_cmp++;
    if (imem_addr_o !== 32'h0000_2FFC) begin n_bad++; $display("FAIL br_target got %h want 00002ffc", imem_addr_o); end
  endtask

  task automatic test_jr_pending();
    imem_ack_i = 1'b0;
    dec_valid_i = 1'b1; jr_i = 1'b1; rs_i = 32'h0000_4000;
    tick();
    clear_dec();
    n_cmp++;
    if (dut.pend_v !== 1'b1 || imem_addr_o !== 32'h0000_2FFC) begin
      n_bad++; $display("FAIL jr_pend pend_v=%b addr=%h want 1 00002ffc", dut.pend_v, imem_addr_o);
    end
    // A second redirect while one is pending must not displace it.
    dec_valid_i = 1'b1; br_i = 1'b1; br_taken_i = 1'b1;
    pcplusD_i = 32'h0000_300C; offset_i = 16'h0000;
    tick();
    clear_dec();
    imem_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (if_valid_o !== 1'b1 || imem_addr_o !== 32'h0000_2FFC) begin
      n_bad++; $display("FAIL jr_slot valid=%b addr=%h want 1 00002ffc", if_valid_o, imem_addr_o);
    end
    tick();
    n_cmp++;
    if (imem_addr_o !== 32'h0000_4000 || dut.pend_v !== 1'b0) begin
      n_bad++; $display("FAIL jr_target addr=%h pend_v=%b want 00004000 0", imem_addr_o, dut.pend_v);
    end
  endtask

  task automatic test_stall();
    imem_ack_i = 1'b1; stall_i = 1'b1;
    #1;
    n_cmp++;
    if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
      n_bad++; $display("FAIL stall_ack valid=%b req=%b want 0 1", if_valid_o, imem_req_o);
    end
    tick();
    imem_ack_i = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b0 || pc_o !== 32'h0000_4000) begin
      n_bad++; $display("FAIL hold_1 req=%b pc=%h want 0 00004000", imem_req_o, pc_o);
    end
    tick();
    stall_i = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL hold_2 req=%b valid=%b want 0 0", imem_req_o, if_valid_o);
    end
    tick();
    imem_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_4000 || if_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL refetch req=%b addr=%h valid=%b want 1 00004000 1", imem_req_o, imem_addr_o, if_valid_o);
    end
    tick();
    n_cmp++;
    if (imem_addr_o !== 32'h0000_4004) begin n_bad++; $display("FAIL after_hold got %h want 00004004", imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    imem_ack_i = 1'b0;
    dec_valid_i = 1'b1; jr_i = 1'b1; rs_i = 32'h0000_5000;
    tick();
    clear_dec();
    n_cmp++;
    if (dut.pend_v !== 1'b1) begin n_bad++; $display("FAIL rmid_pend got %b want 1", dut.pend_v); end
    rst = 1'b0; imem_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", if_valid_o); end
    tick();
    n_cmp++;
    if (pc_o !== 32'h0000_3000 || dut.pend_v !== 1'b0 || imem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL rmid_state pc=%h pend_v=%b req=%b want 00003000 0 0", pc_o, dut.pend_v, imem_req_o);
    end
    rst = 1'b1;
    tick();
    #1;
    n_cmp++;
    if (imem_addr_o !== 32'h0000_3000 || if_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL rmid_resume addr=%h valid=%b want 00003000 1", imem_addr_o, if_valid_o);
    end
    tick();
    n_cmp++;
    if (imem_addr_o !== 32'h0000_3004) begin n_bad++; $display("FAIL rmid_next got %h want 00003004", imem_addr_o); end
  endtask

  task automatic test_wrap();
    imem_ack_i = 1'b1;
    dec_valid_i = 1'b1; jr_i = 1'b1; rs_i = 32'hFFFF_FFFC;
    tick();
    clear_dec();
    n_cmp++;
    if (imem_addr_o !== 32'hFFFF_FFFC || pcplus_o !== 32'h0000_0000) begin
      n_bad++; $display("FAIL wrap_pcplus addr=%h pcplus=%h want fffffffc 00000000", imem_addr_o, pcplus_o);
    end
    tick();
    n_cmp++;
    if (imem_addr_o !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_next got %h want 00000000", imem_addr_o); end
  endtask

  task automatic test_jump();
    imem_ack_i = 1'b1;
    dec_valid_i = 1'b1; j_i = 1'b1; pcplusD_i = 32'hA000_0008; jidx_i = 26'h000_0100;
    tick();
    clear_dec();
    n_cmp++;
    if (imem_addr_o !== 32'hA000_0400) begin n_bad++; $display("FAIL j_target got %h want a0000400", imem_addr_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_seq();
    test_wait();
    test_branch();
    test_jr_pending();
    test_stall();
    test_reset_mid();
    test_jump();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout compared=%0d want completion before 100000", n_cmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Fetch-stage sequencer. Owns the PC register and drives an `npc` instance, supplying `npcop`, `pcplus` and `absaddress`.
- Runs a req/ack handshake to instruction memory that tolerates wait states.
- Applies branch and jump redirects from the D stage with MIPS delay-slot semantics, including redirects that arrive while a fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset and fetched first.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- stall_i  in  1  hazard stall from decode; IF/ID must not advance.
- dec_valid_i  in  1  D stage holds a valid instruction.
- br_i  in  1  D instruction is a conditional branch.
- br_taken_i  in  1  D-stage comparator result.
- j_i  in  1  D instruction is j/jal.
- jr_i  in  1  D instruction is jr/jalr.
- pcplusD_i  in  32  PC+4 of the D instruction.
- offset_i  in  16  branch immediate.
- jidx_i  in  26  jump instr_index.
- rs_i  in  32  register target for jr/jalr.
- imem_ack_i  in  1  instruction memory returns data for imem_addr_o this cycle.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; equals pc_o.
- pc_o  out  32  current fetch PC.
- pcplus_o  out  32  pc_o+4, forwarded to IF/ID.
- if_valid_o  out  1  fetched instruction is accepted into IF/ID this cycle.

Behaviour:
- Reset (rst==0 at an edge):
  - pc=RESET_PC, state=IDLE, pend_v=0, pend_tgt=0.
  - Outputs: imem_req_o=0, if_valid_o=0.
  - An ack arriving in IDLE is ignored.
- State machine {IDLE, FETCH, HOLD}:
  - IDLE: after the first edge with rst==1, go to FETCH.
  - FETCH:
    - imem_req_o=1. imem_addr_o=pc is held stable until ack.
    - ack & !stall_i: if_valid_o=1 (combinational). pc<=next_pc. Stay in FETCH, so back-to-back requests are issued with the new address next cycle.
    - ack & stall_i: if_valid_o=0, pc unchanged, go to HOLD.
    - no ack: wait.
  - HOLD:
    - imem_req_o=0.
    - When stall_i==0, go to FETCH and refetch the same pc.
- Redirect:
  - redir = dec_valid_i & !stall_i & (jr_i | j_i | (br_i & br_taken_i)). Evaluated every cycle, independent of state.
  - Priority is jr > j > br.
  - Targets:
    - jr: rs_i.
    - j: {pcplusD_i[31:28], jidx_i, 2'b00}.
    - br: computed by npc with npcop=01 as pcplusD_i + sext(offset)<<2.
- npc control (next_pc computation):
  - pend_v: npcop=10, absaddress=pend_tgt.
  - else redir & jr/j: npcop=10, absaddress=target.
  - else redir & br: npcop=01.
  - else: npcop=00 (pcplus).
- Delay slot rule: the fetch completing in or after the redirect cycle is the delay slot.
  - The redirect applies to the pc update at that fetch's accepting ack.
  - If redir occurs and no accepting ack occurs in the same cycle: pend_v<=1 and pend_tgt<=the resolved 32-bit target (the branch target is computed internally).
  - The next accepting ack loads pc<=pend_tgt and clears pend_v.
- A redir while pend_v==1 (branch in delay slot, architecturally illegal) is ignored; the pending target wins.
- Reset mid-fetch: req drops the next cycle and pend_v is cleared.
- Arithmetic is modulo 2^32: pc=32'hFFFF_FFFC gives pcplus_o=0, and sequential next pc is 0.
- Zero-wait memory (ack tied high) sustains one instruction per cycle.

Decomposition:
- Shared package:
  - NPCOP_PLUS4 = 2'b00, NPCOP_BRANCH = 2'b01, NPCOP_ABS = 2'b10.
  - FSM state encoding {IDLE, FETCH, HOLD}.
  - RESET_PC default.
- One sub-module: the existing `npc` (with its `signext`), instantiated once.
- Pending-target register and FSM live in pc_seq.

Test Plan:
- Reset, then ack tied 1, no redirects -> imem_addr_o 3000, 3004, 3008 on consecutive cycles; if_valid_o=1 each cycle; first req one cycle after rst rises.
- Ack delayed 3 cycles on the fetch at 3004 -> imem_addr_o holds 3004 for 4 cycles; if_valid_o pulses only on the ack cycle; next address 3008.
- Branch taken in D with pcplusD_i=300C, offset_i=16'hFFFC, plus same-cycle ack -> next fetch 2FFC.
- jr with rs_i=0000_4000 asserted while the delay-slot fetch is waiting; ack 2 cycles later -> pend_v set; the address after ack is 4000; pend_v cleared.
- stall_i=1 on an ack cycle, held 2 cycles -> if_valid_o=0; req low during HOLD; same pc refetched after stall drops.
- rst driven low mid-FETCH with pend_v=1, ack arriving the same cycle -> pc=3000, pend_v=0, ack ignored; fetch resumes at 3000.
